// File: rtl/fir_pkg.sv
// Shared widths, FSM encodings, default taps and output saturation for the TDM FIR.
// Widths here define the packed sample, coefficient and accumulator formats.
package fir_pkg;

    localparam int NCH   = 4;
    localparam int NTAPS = 8;
    localparam int DW    = 12;
    localparam int CW    = 8;
    localparam int AW    = 24;
    localparam int FRAC  = 6;
    localparam int CHW   = $clog2(NCH);
    localparam int TW    = $clog2(NTAPS);
    localparam int PW    = CW + DW;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam logic signed [CW-1:0] COEF_DEFAULT [NTAPS] =
        '{8'sd0, -8'sd1, 8'sd6, 8'sd28, 8'sd28, 8'sd6, -8'sd1, 8'sd0};

    // Drop FRAC bits, then clamp anything that no longer fits in DW bits.
    function automatic logic signed [DW-1:0] saturate(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> FRAC;
        if (&s[AW-1:DW-1] || ~|s[AW-1:DW-1])
            return s[DW-1:0];
        else if (s[AW-1])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

endpackage

// File: rtl/fir_tdm_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last accepted requester.
// Latency: combinational grant; pointer moves on the clock edge carrying accept.
// Backpressure: grant is forced to zero while en is low.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        // Offset N wraps back to ptr itself, so the last winner is checked last.
        for (int i = 1; i <= N; i++) begin
            idx = ptr + IW'(i);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= IW'(N - 1);
        else if (accept)
            ptr <= grant_idx;
    end

endmodule

// File: rtl/fir_tdm_sched.sv
// Time-shared 8-tap FIR: round-robin picks a channel, one tap per cycle through one multiplier.
// Latency: accept at edge T, out_valid from edge T+NTAPS+1; one sample per NTAPS+3 cycles.
// Backpressure: result held in OUT until out_ready; no inputs or coef writes accepted meanwhile.
module fir_tdm_sched
    import fir_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH*DW-1:0]   in_data,
    output logic [NCH-1:0]      in_ready,
    input  logic                coef_we,
    input  logic [TW-1:0]       coef_addr,
    input  logic [CW-1:0]       coef_wdata,
    output logic                coef_ready,
    output logic                out_valid,
    output logic [CHW-1:0]      out_ch,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready
);

    localparam int KW = $clog2(NTAPS + 1);

    logic [1:0]              state;
    logic [KW-1:0]           k;
    logic [CHW-1:0]          gsel;
    logic [CHW-1:0]          grant_idx;
    logic [TW-1:0]           tap;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    acc_sum;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    mul;
    logic signed [CW-1:0]    coef [NTAPS];
    logic signed [DW-1:0]    dl   [NCH][NTAPS];
    logic                    arb_en;
    logic                    accept;

    assign arb_en     = (state == IDLE) && !coef_we && !rst;
    assign coef_ready = (state == IDLE) && !rst;
    assign accept     = |(in_valid & in_ready);
    assign tap        = k[TW-1:0];
    assign mul        = coef[tap] * dl[gsel][tap];
    assign acc_sum    = acc + {{(AW-PW){prod[PW-1]}}, prod};

    rr_arbiter #(
        .N  (NCH),
        .IW (CHW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .en        (arb_en),
        .accept    (accept),
        .grant     (in_ready),
        .grant_idx (grant_idx)
    );

    // The product is registered, so MAC spends NTAPS+1 cycles: the last one only adds tap NTAPS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            gsel      <= '0;
            acc       <= '0;
            prod      <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            for (int t = 0; t < NTAPS; t++)
                coef[t] <= COEF_DEFAULT[t];
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t < NTAPS; t++)
                    dl[c][t] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we) begin
                        coef[coef_addr] <= coef_wdata;
                    end else if (accept) begin
                        for (int t = NTAPS - 1; t > 0; t--)
                            dl[grant_idx][t] <= dl[grant_idx][t-1];
                        dl[grant_idx][0] <= in_data[grant_idx*DW +: DW];
                        gsel  <= grant_idx;
                        acc   <= '0;
                        prod  <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc  <= acc_sum;
                    prod <= mul;
                    k    <= k + KW'(1);
                    if (k == KW'(NTAPS)) begin
                        out_data  <= saturate(acc_sum);
                        out_ch    <= gsel;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_sched.sv
// Directed bench for fir_tdm_sched: reset, impulse, round-robin, backpressure,
// saturation, coefficient writes and mid-MAC reset, all against hand-computed values.
module tb_fir_tdm_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [47:0] in_data;
    logic [3:0]  in_ready;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [7:0]  coef_wdata;
    logic        coef_ready;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [11:0] out_data;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    fir_tdm_sched dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_ready (coef_ready),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [11:0] v);
        in_data = '0;
        in_data[ch*12 +: 12] = v;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 4'hF;
        cyc();
        chk("rst.in_ready", in_ready, 0);
        chk("rst.coef_ready", coef_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_ch", out_ch, 0);
        chk("rst.out_data", $signed(out_data), 0);
        rst = 1'b0;
        #1;
        chk("rst.coef_ready_idle", coef_ready, 1);
        chk("rst.first_grant", in_ready, 1);
        in_valid = 4'h0;
    endtask

    // One full transaction: grant check, accept, latency, result, handshake.
    task automatic run(input string tag, input int ch, input int exp);
        int n;
        #1;
        chk({tag, ".in_ready"}, in_ready, 1 << ch);
        cyc();
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, ".latency"}, n, 9);
        chk({tag, ".out_ch"}, out_ch, ch);
        chk({tag, ".out_data"}, $signed(out_data), exp);
        cyc();
        chk({tag, ".out_valid_clr"}, out_valid, 0);
    endtask

    int imp  [8]  = '{0, -1, 6, 28, 28, 6, -1, 0};
    int rr   [12] = '{0, 0, 0, 0, -1, -2, 1, 0, 5, 10, -5, 0};
    int satp [8]  = '{0, -32, 159, 1055, 1951, 2047, 2047, 2047};
    int satn [8]  = '{2047, 2047, 1791, -1, -1793, -2048, -2048, -2048};
    int imp3 [7]  = '{-1, 6, 64, 28, 6, -1, 0};
    int post [4]  = '{0, -1, 6, 28};

    initial begin
        int n;
        int hits;
        rst        = 1'b1;
        in_valid   = 4'h0;
        in_data    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        out_ready  = 1'b1;
        repeat (2) cyc();
        do_reset();

        // Impulse on ch0 reads back the default taps.
        in_valid = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            set_ch(0, (i == 0) ? 12'd64 : 12'd0);
            run("imp", 0, imp[i]);
        end
        in_valid = 4'h0;

        // All channels requesting: grants rotate 0,1,2,3 with independent histories.
        do_reset();
        in_valid = 4'hF;
        in_data  = {12'd0, 12'hFC0, 12'd128, 12'd64};
        for (int i = 0; i < 12; i++)
            run("rr", i % 4, rr[i]);

        // Hold ch2's result with out_ready low for 20 cycles.
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        #1;
        chk("bp.in_ready", in_ready, 4'b0100);
        cyc();
        in_valid = 4'hF;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("bp.latency", n, 9);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("bp.out_valid", out_valid, 1);
            chk("bp.out_ch", out_ch, 2);
            chk("bp.out_data", $signed(out_data), -33);
            chk("bp.in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.no_comb_path", in_ready, 0);
        cyc();
        chk("bp.out_valid_clr", out_valid, 0);
        chk("bp.next_grant", in_ready, 4'b1000);
        in_valid = 4'h0;

        // Saturation on ch1 in both directions.
        do_reset();
        in_valid = 4'b0010;
        set_ch(1, 12'd2047);
        for (int i = 0; i < 8; i++)
            run("satp", 1, satp[i]);
        set_ch(1, 12'h800);
        for (int i = 0; i < 8; i++)
            run("satn", 1, satn[i]);
        in_valid = 4'h0;

        // Coefficient write wins over a pending input in IDLE.
        do_reset();
        in_valid   = 4'b1000;
        set_ch(3, 12'd64);
        coef_we    = 1'b1;
        coef_addr  = 3'd3;
        coef_wdata = 8'd64;
        #1;
        chk("cw.in_ready_blocked", in_ready, 0);
        chk("cw.coef_ready", coef_ready, 1);
        cyc();
        coef_we = 1'b0;
        #1;
        chk("cw.imp0.in_ready", in_ready, 4'b1000);
        cyc();
        cyc();
        // This write lands during MAC and must not reach tap 4.
        coef_we    = 1'b1;
        coef_addr  = 3'd4;
        coef_wdata = 8'd0;
        #1;
        chk("cw.coef_ready_mac", coef_ready, 0);
        cyc();
        coef_we = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("cw.imp0.out_data", $signed(out_data), 0);
        chk("cw.imp0.out_ch", out_ch, 3);
        cyc();
        set_ch(3, 12'd0);
        for (int i = 0; i < 7; i++)
            run("cw.imp", 3, imp3[i]);
        in_valid = 4'h0;

        // Reset in the middle of a MAC discards the computation.
        in_valid = 4'b0001;
        set_ch(0, 12'd64);
        #1;
        chk("abort.in_ready", in_ready, 1);
        cyc();
        in_valid = 4'h0;
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (out_valid === 1'b1)
                hits++;
        end
        chk("abort.no_out_valid", hits, 0);
        chk("abort.out_data", $signed(out_data), 0);
        chk("abort.out_ch", out_ch, 0);

        // Reset restored default taps and cleared ch0's history.
        in_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            set_ch(0, (i == 0) ? 12'd64 : 12'd0);
            run("post", 0, post[i]);
        end
        in_valid = 4'h0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
